vector_mem_sequencer: RTL and testbench

//  Pipeline-side initiator for the byte-serial vector memory port. Accepts one

---
 rtl/vmem_pkg.sv | 29 ++
 rtl/vmem_watchdog.sv | 29 ++
 rtl/vector_mem_sequencer.sv | 177 +++++++++++++++++
 tb/tb_vector_mem_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vmem_pkg.sv
// Shared types and constants for the vector memory sequencer.
package vmem_pkg;

    localparam int LANE_W    = 8;
    localparam int NUM_LANES = 4;
    localparam int WORD_W    = LANE_W * NUM_LANES;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    typedef struct packed {
        logic              load;
        logic              store;
        logic              scalar;
        logic [WORD_W-1:0] base;
        logic [WORD_W-1:0] offs;
        logic [WORD_W-1:0] data;
        logic [4:0]        dst;
    } op_t;

    // A scalar access only carries lane 0; the upper lanes read as zero.
    function automatic logic [WORD_W-1:0] lane0_only(input logic [WORD_W-1:0] w);
        return {{(WORD_W-LANE_W){1'b0}}, w[LANE_W-1:0]};
    endfunction

endpackage

// File: rtl/vmem_watchdog.sv
// Wait-cycle counter for one memory access; flags the cycle that would
// reach the timeout so the sequencer can abort on that same edge.
module vmem_watchdog #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_inc,
    output logic o_expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] r_count;

    // Count stalled cycles; cleared on reset and at the start of each access.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + CW'(1);
        end
    end

    // This stalled cycle is the TIMEOUT_CYCLES-th one.
    assign o_expired = i_inc && (r_count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/vector_mem_sequencer.sv
// Pipeline-side initiator for the byte-serial vector memory port: takes one
// load/store, holds the memory request while the memory stalls, returns
// load data as a one-cycle writeback, and aborts on a stuck memory.
module vector_mem_sequencer
    import vmem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             OP_VALID,
    input  logic             OP_LOAD,
    input  logic             OP_STORE,
    input  logic             OP_SCALAR,
    input  logic [31:0]      OP_BASE,
    input  logic [31:0]      OP_OFFS,
    input  logic [31:0]      OP_DATA,
    input  logic [4:0]       OP_DST,
    output logic             OP_READY,
    output logic             STALL,
    output logic             MEM_RE,
    output logic             MEM_WE,
    output logic             MEM_SO,
    output logic [31:0]      MEM_BA,
    output logic [31:0]      MEM_VO,
    output logic [31:0]      MEM_WD,
    input  logic             MEM_SP,
    input  logic [31:0]      MEM_RD,
    output logic             WB_VALID,
    output logic [4:0]       WB_DST,
    output logic             WB_VEC,
    output logic [31:0]      WB_DATA,
    output logic             ERR_ILLEGAL,
    output logic             ERR_TIMEOUT,
    output logic [CNT_W-1:0] PERF_VEC_OPS
);

    // Handshake: an op transfers on a rising edge where OP_VALID and OP_READY
    // are both high; OP_READY is high only in IDLE, so at most one op is in
    // flight and upstream must hold OP_* while STALL is high.

    state_t           r_state;
    state_t           w_next;
    op_t              r_op;
    logic [31:0]      r_wb_data;
    logic [4:0]       r_wb_dst;
    logic             r_wb_vec;
    logic             r_err_illegal;
    logic             r_err_timeout;
    logic [CNT_W-1:0] r_perf;

    logic w_accept;
    logic w_illegal;
    logic w_complete;
    logic w_timeout;
    logic w_wd_inc;
    logic w_expired;

    assign w_wd_inc = (r_state == S_ACCESS) && MEM_SP;

    vmem_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .i_clk    (CLK),
        .i_rst    (RST),
        .i_clear  (w_accept),
        .i_inc    (w_wd_inc),
        .o_expired(w_expired)
    );

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode, transfer events and memory-side outputs.
    always_comb begin
        w_next     = r_state;
        w_accept   = 1'b0;
        w_illegal  = 1'b0;
        w_complete = 1'b0;
        w_timeout  = 1'b0;
        OP_READY   = 1'b0;
        STALL      = 1'b0;
        MEM_RE     = 1'b0;
        MEM_WE     = 1'b0;
        MEM_SO     = 1'b0;
        MEM_BA     = '0;
        MEM_VO     = '0;
        MEM_WD     = '0;
        case (r_state)
            S_IDLE: begin
                OP_READY = 1'b1;
                if (OP_VALID) begin
                    if (OP_LOAD ^ OP_STORE) begin
                        w_accept = 1'b1;
                        w_next   = S_ACCESS;
                    end else if (OP_LOAD && OP_STORE) begin
                        w_illegal = 1'b1;
                    end
                end
            end
            S_ACCESS: begin
                STALL  = 1'b1;
                MEM_RE = r_op.load;
                MEM_WE = r_op.store;
                MEM_SO = r_op.scalar;
                MEM_BA = r_op.base;
                MEM_VO = r_op.offs;
                MEM_WD = r_op.scalar ? lane0_only(r_op.data) : r_op.data;
                if (!MEM_SP) begin
                    w_complete = 1'b1;
                    w_next     = r_op.load ? S_RESP : S_IDLE;
                end else if (w_expired) begin
                    w_timeout = 1'b1;
                    w_next    = S_IDLE;
                end
            end
            S_RESP: begin
                STALL  = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Op capture, writeback data, error pulses and the vector-op counter.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_op          <= '0;
            r_wb_data     <= '0;
            r_wb_dst      <= '0;
            r_wb_vec      <= 1'b0;
            r_err_illegal <= 1'b0;
            r_err_timeout <= 1'b0;
            r_perf        <= '0;
        end else begin
            r_err_illegal <= w_illegal;
            r_err_timeout <= w_timeout;
            if (w_accept) begin
                r_op.load   <= OP_LOAD;
                r_op.store  <= OP_STORE;
                r_op.scalar <= OP_SCALAR;
                r_op.base   <= OP_BASE;
                r_op.offs   <= OP_OFFS;
                r_op.data   <= OP_DATA;
                r_op.dst    <= OP_DST;
            end
            if (w_complete) begin
                if (r_op.load) begin
                    r_wb_data <= r_op.scalar ? lane0_only(MEM_RD) : MEM_RD;
                    r_wb_dst  <= r_op.dst;
                    r_wb_vec  <= ~r_op.scalar;
                end
                if (!r_op.scalar) begin
                    r_perf <= r_perf + CNT_W'(1);
                end
            end
        end
    end

    assign WB_VALID     = (r_state == S_RESP);
    assign WB_DST       = r_wb_dst;
    assign WB_VEC       = r_wb_vec;
    assign WB_DATA      = r_wb_data;
    assign ERR_ILLEGAL  = r_err_illegal;
    assign ERR_TIMEOUT  = r_err_timeout;
    assign PERF_VEC_OPS = r_perf;

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Directed bench for vector_mem_sequencer: inputs change and outputs are
// observed on the falling edge, half a cycle away from the active edge.
module tb_vector_mem_sequencer;

    logic        CLK = 1'b0;
    logic        RST;
    logic        OP_VALID, OP_LOAD, OP_STORE, OP_SCALAR;
    logic [31:0] OP_BASE, OP_OFFS, OP_DATA;
    logic [4:0]  OP_DST;
    logic        OP_READY, STALL, MEM_RE, MEM_WE, MEM_SO;
    logic [31:0] MEM_BA, MEM_VO, MEM_WD;
    logic        MEM_SP;
    logic [31:0] MEM_RD;
    logic        WB_VALID;
    logic [4:0]  WB_DST;
    logic        WB_VEC;
    logic [31:0] WB_DATA;
    logic        ERR_ILLEGAL, ERR_TIMEOUT;
    logic [15:0] PERF_VEC_OPS;

    int checks   = 0;
    int failures = 0;

    // Clock and reset block.
    always #5 CLK = ~CLK;

    vector_mem_sequencer #(.TIMEOUT_CYCLES(16), .CNT_W(16)) dut (
        .CLK(CLK), .RST(RST),
        .OP_VALID(OP_VALID), .OP_LOAD(OP_LOAD), .OP_STORE(OP_STORE),
        .OP_SCALAR(OP_SCALAR), .OP_BASE(OP_BASE), .OP_OFFS(OP_OFFS),
        .OP_DATA(OP_DATA), .OP_DST(OP_DST), .OP_READY(OP_READY), .STALL(STALL),
        .MEM_RE(MEM_RE), .MEM_WE(MEM_WE), .MEM_SO(MEM_SO), .MEM_BA(MEM_BA),
        .MEM_VO(MEM_VO), .MEM_WD(MEM_WD), .MEM_SP(MEM_SP), .MEM_RD(MEM_RD),
        .WB_VALID(WB_VALID), .WB_DST(WB_DST), .WB_VEC(WB_VEC), .WB_DATA(WB_DATA),
        .ERR_ILLEGAL(ERR_ILLEGAL), .ERR_TIMEOUT(ERR_TIMEOUT),
        .PERF_VEC_OPS(PERF_VEC_OPS)
    );

    // Control bits packed as {OP_READY,STALL,MEM_RE,MEM_WE,MEM_SO,WB_VALID,WB_VEC,ERR_ILLEGAL,ERR_TIMEOUT}.
    logic [8:0] ctl;
    assign ctl = {OP_READY, STALL, MEM_RE, MEM_WE, MEM_SO, WB_VALID, WB_VEC, ERR_ILLEGAL, ERR_TIMEOUT};

    // Driver tasks.
    task automatic step();
        @(negedge CLK);
    endtask

    task automatic drive_op(input logic ld, input logic st, input logic sc,
                            input logic [31:0] base, input logic [31:0] offs,
                            input logic [31:0] data, input logic [4:0] dst);
        OP_VALID  = 1'b1;
        OP_LOAD   = ld;
        OP_STORE  = st;
        OP_SCALAR = sc;
        OP_BASE   = base;
        OP_OFFS   = offs;
        OP_DATA   = data;
        OP_DST    = dst;
    endtask

    task automatic clear_op();
        OP_VALID  = 1'b0;
        OP_LOAD   = 1'b0;
        OP_STORE  = 1'b0;
        OP_SCALAR = 1'b0;
        OP_BASE   = '0;
        OP_OFFS   = '0;
        OP_DATA   = '0;
        OP_DST    = '0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        clear_op();
        MEM_SP = 1'b0;
        MEM_RD = '0;
        step();
        step();
        checks++;
        if (ctl !== 9'b100000000) begin
            failures++;
            $display("FAIL reset_ctl: got %b want %b", ctl, 9'b100000000);
        end
        checks++;
        if ({MEM_BA, MEM_VO, MEM_WD, WB_DATA, WB_DST, PERF_VEC_OPS} !== '0) begin
            failures++;
            $display("FAIL reset_buses: ba=%h vo=%h wd=%h wbd=%h dst=%h perf=%h want all 0",
                     MEM_BA, MEM_VO, MEM_WD, WB_DATA, WB_DST, PERF_VEC_OPS);
        end
        RST = 1'b0;
        step();
    endtask

    task automatic test_scalar_load();
        MEM_SP = 1'b0;
        MEM_RD = 32'h123456AB;
        drive_op(1'b1, 1'b0, 1'b1, 32'h10, 32'h0, 32'h0, 5'd3);
        step();
        clear_op();
        checks++;
        if (ctl !== 9'b011010000 || MEM_BA !== 32'h10) begin
            failures++;
            $display("FAIL sload_access: ctl=%b ba=%h want ctl=011010000 ba=00000010", ctl, MEM_BA);
        end
        step();
        checks++;
        if (ctl !== 9'b010001000 || WB_DATA !== 32'h000000AB || WB_DST !== 5'd3) begin
            failures++;
            $display("FAIL sload_wb: ctl=%b data=%h dst=%0d want ctl=010001000 data=000000ab dst=3",
                     ctl, WB_DATA, WB_DST);
        end
        step();
        checks++;
        if (ctl !== 9'b100000000 || WB_DATA !== 32'h000000AB || PERF_VEC_OPS !== 16'd0) begin
            failures++;
            $display("FAIL sload_idle: ctl=%b data=%h perf=%0d want ctl=100000000 data=000000ab perf=0",
                     ctl, WB_DATA, PERF_VEC_OPS);
        end
    endtask

    task automatic test_vector_load();
        MEM_SP = 1'b1;
        MEM_RD = 32'h44332211;
        drive_op(1'b1, 1'b0, 1'b0, 32'h2000, 32'h0C080400, 32'h0, 5'd7);
        step();
        clear_op();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (ctl !== 9'b011000000 || MEM_BA !== 32'h2000 || MEM_VO !== 32'h0C080400) begin
                failures++;
                $display("FAIL vload_hold[%0d]: ctl=%b ba=%h vo=%h want ctl=011000000 ba=00002000 vo=0c080400",
                         i, ctl, MEM_BA, MEM_VO);
            end
            if (i == 4) MEM_SP = 1'b0;
            step();
        end
        checks++;
        if (ctl !== 9'b010001100 || WB_DATA !== 32'h44332211 || WB_DST !== 5'd7 || PERF_VEC_OPS !== 16'd1) begin
            failures++;
            $display("FAIL vload_wb: ctl=%b data=%h dst=%0d perf=%0d want ctl=010001100 data=44332211 dst=7 perf=1",
                     ctl, WB_DATA, WB_DST, PERF_VEC_OPS);
        end
        step();
        checks++;
        if (ctl !== 9'b100000100) begin
            failures++;
            $display("FAIL vload_idle: ctl=%b want 100000100", ctl);
        end
    endtask

    task automatic test_vector_store();
        MEM_SP = 1'b1;
        drive_op(1'b0, 1'b1, 1'b0, 32'h300, 32'h03020100, 32'hDEADBEEF, 5'd9);
        step();
        clear_op();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (ctl !== 9'b010100100 || MEM_WD !== 32'hDEADBEEF || MEM_BA !== 32'h300) begin
                failures++;
                $display("FAIL vstore_hold[%0d]: ctl=%b wd=%h ba=%h want ctl=010100100 wd=deadbeef ba=00000300",
                         i, ctl, MEM_WD, MEM_BA);
            end
            if (i == 4) MEM_SP = 1'b0;
            step();
        end
        checks++;
        if (ctl !== 9'b100000100 || PERF_VEC_OPS !== 16'd2 || WB_DATA !== 32'h44332211) begin
            failures++;
            $display("FAIL vstore_done: ctl=%b perf=%0d wbd=%h want ctl=100000100 perf=2 wbd=44332211",
                     ctl, PERF_VEC_OPS, WB_DATA);
        end
    endtask

    task automatic test_timeout();
        MEM_SP = 1'b1;
        drive_op(1'b1, 1'b0, 1'b0, 32'h4000, 32'h01010101, 32'h0, 5'd12);
        step();
        clear_op();
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (MEM_RE !== 1'b1 || ERR_TIMEOUT !== 1'b0 || WB_VALID !== 1'b0) begin
                failures++;
                $display("FAIL tmo_wait[%0d]: re=%b err=%b wbv=%b want re=1 err=0 wbv=0",
                         i, MEM_RE, ERR_TIMEOUT, WB_VALID);
            end
            step();
        end
        checks++;
        if (ctl !== 9'b100000101 || PERF_VEC_OPS !== 16'd2 || WB_DST !== 5'd7) begin
            failures++;
            $display("FAIL tmo_abort: ctl=%b perf=%0d dst=%0d want ctl=100000101 perf=2 dst=7",
                     ctl, PERF_VEC_OPS, WB_DST);
        end
        MEM_SP = 1'b0;
        step();
        checks++;
        if (ctl !== 9'b100000100) begin
            failures++;
            $display("FAIL tmo_pulse: ctl=%b want 100000100", ctl);
        end
    endtask

    task automatic test_illegal();
        drive_op(1'b1, 1'b1, 1'b0, 32'h500, 32'h0, 32'h0, 5'd1);
        step();
        clear_op();
        checks++;
        if (ctl !== 9'b100000110) begin
            failures++;
            $display("FAIL illegal_pulse: ctl=%b want 100000110", ctl);
        end
        // Valid with neither load nor store set is ignored.
        drive_op(1'b0, 1'b0, 1'b0, 32'h600, 32'h0, 32'h0, 5'd2);
        step();
        clear_op();
        checks++;
        if (ctl !== 9'b100000100) begin
            failures++;
            $display("FAIL illegal_clear_noop: ctl=%b want 100000100", ctl);
        end
        step();
        checks++;
        if (ctl !== 9'b100000100) begin
            failures++;
            $display("FAIL noop_idle: ctl=%b want 100000100", ctl);
        end
    endtask

    task automatic test_back_to_back();
        MEM_SP = 1'b0;
        MEM_RD = 32'hCAFE0055;
        drive_op(1'b0, 1'b1, 1'b1, 32'h20, 32'h0, 32'h000000EF, 5'd0);
        step();
        clear_op();
        checks++;
        if (ctl !== 9'b010110100 || MEM_BA !== 32'h20) begin
            failures++;
            $display("FAIL b2b_store: ctl=%b ba=%h want ctl=010110100 ba=00000020", ctl, MEM_BA);
        end
        step();
        checks++;
        if (OP_READY !== 1'b1) begin
            failures++;
            $display("FAIL b2b_ready: got %b want 1", OP_READY);
        end
        drive_op(1'b1, 1'b0, 1'b1, 32'h21, 32'h0, 32'h0, 5'd31);
        step();
        clear_op();
        checks++;
        if (ctl !== 9'b011010100 || MEM_BA !== 32'h21) begin
            failures++;
            $display("FAIL b2b_load: ctl=%b ba=%h want ctl=011010100 ba=00000021", ctl, MEM_BA);
        end
        step();
        checks++;
        if (ctl !== 9'b010001000 || WB_DATA !== 32'h00000055 || WB_DST !== 5'd31 || PERF_VEC_OPS !== 16'd2) begin
            failures++;
            $display("FAIL b2b_wb: ctl=%b data=%h dst=%0d perf=%0d want ctl=010001000 data=00000055 dst=31 perf=2",
                     ctl, WB_DATA, WB_DST, PERF_VEC_OPS);
        end
        step();
    endtask

    task automatic test_rst_mid_access();
        MEM_SP = 1'b1;
        MEM_RD = 32'h99999999;
        drive_op(1'b1, 1'b0, 1'b0, 32'h7000, 32'h04030201, 32'h0, 5'd5);
        step();
        clear_op();
        step();
        checks++;
        if (MEM_RE !== 1'b1 || STALL !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_pre: re=%b stall=%b want re=1 stall=1", MEM_RE, STALL);
        end
        RST = 1'b1;
        step();
        checks++;
        if (ctl !== 9'b100000000 || {MEM_BA, MEM_VO, WB_DATA, WB_DST, PERF_VEC_OPS} !== '0) begin
            failures++;
            $display("FAIL rst_mid: ctl=%b ba=%h vo=%h wbd=%h dst=%h perf=%0d want ctl=100000000 and zero buses",
                     ctl, MEM_BA, MEM_VO, WB_DATA, WB_DST, PERF_VEC_OPS);
        end
        RST = 1'b0;
        MEM_SP = 1'b0;
        step();
        checks++;
        if (ctl !== 9'b100000000) begin
            failures++;
            $display("FAIL rst_mid_after: ctl=%b want 100000000", ctl);
        end
    endtask

    initial begin
        test_reset();
        test_scalar_load();
        test_vector_load();
        test_vector_store();
        test_timeout();
        test_illegal();
        test_back_to_back();
        test_rst_mid_access();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
